// File: rtl/prog_interval_timer.sv
// Programmable up-counting interval timer with prescaler, one-shot/periodic modes
// and start/stop/pause control. count, busy and done are all registered.
module prog_interval_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] count_r, count_s;
    logic [WIDTH-1:0] load_r, load_s;
    logic [PW-1:0]    presc_r, presc_s;
    logic             mode_r, mode_s;
    logic             busy_r;
    logic             done_r, done_s;

    // State, counters, latched configuration and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            count_r <= '0;
            load_r  <= '0;
            presc_r <= '0;
            mode_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            load_r  <= load_s;
            presc_r <= presc_s;
            mode_r  <= mode_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= done_s;
        end
    end

    // Next-state logic: stop beats start beats pause beats counting
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        load_s  = load_r;
        presc_s = presc_r;
        mode_s  = mode_r;
        done_s  = 1'b0;
        if (stop) begin
            state_s = IDLE;
            count_s = '0;
            presc_s = '0;
        end else if (start) begin
            state_s = RUN;
            count_s = '0;
            presc_s = '0;
            load_s  = load;
            mode_s  = mode;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN, PAUSED: begin
                    if (pause) begin
                        state_s = PAUSED;
                    end else begin
                        // Releasing pause resumes counting in the same cycle
                        state_s = RUN;
                        if (enable) begin
                            if (presc_r == PRESC_LAST) begin
                                presc_s = '0;
                                if (count_r == load_r) begin
                                    count_s = '0;
                                    done_s  = 1'b1;
                                    if (!mode_r) begin
                                        state_s = IDLE;
                                    end else begin
                                        state_s = RUN;
                                    end
                                end else begin
                                    count_s = count_r + WIDTH'(1'b1);
                                end
                            end else begin
                                presc_s = presc_r + PW'(1'b1);
                            end
                        end else begin
                            presc_s = presc_r;
                        end
                    end
                end
                default: begin
                    state_s = IDLE;
                    count_s = '0;
                    presc_s = '0;
                end
            endcase
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_prog_interval_timer.sv
// Directed self-checking bench: u_dut runs with PRESCALE=4, u_dut1 with PRESCALE=1.
module tb_prog_interval_timer;

    logic       clk;
    logic       reset_n;
    logic       enable, start, stop, pause, mode;
    logic [7:0] load, count;
    logic       busy, done;
    logic       start1, stop1, pause1, mode1;
    logic [7:0] load1, count1;
    logic       busy1, done1;

    int checks   = 0;
    int failures = 0;
    logic seen_done;

    prog_interval_timer #(.WIDTH(8), .PRESCALE(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .stop(stop),
        .pause(pause), .mode(mode), .load(load), .count(count), .busy(busy), .done(done)
    );

    prog_interval_timer #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start1), .stop(stop1),
        .pause(pause1), .mode(mode1), .load(load1), .count(count1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 1'b0; load = 8'd0;
        start1 = 1'b0; stop1 = 1'b0; pause1 = 1'b0; mode1 = 1'b0; load1 = 8'd0;
        seen_done = 1'b0;
        #2;
        check("rst_count", count, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1);

        // Periodic, load=3: count steps every 4 cycles, done every 16
        load = 8'd3; mode = 1'b1; enable = 1'b1; start = 1'b1;
        step(1); start = 1'b0;
        check("p_e0_busy", busy, 1'b1);
        check("p_e0_count", count, 8'd0);
        step(3);  check("p_e3_count", count, 8'd0);
        step(1);  check("p_e4_count", count, 8'd1);
        step(4);  check("p_e8_count", count, 8'd2);
        step(4);  check("p_e12_count", count, 8'd3);
        step(3);  check("p_e15_done", done, 1'b0);
        step(1);  check("p_e16_done", done, 1'b1);
        check("p_e16_count", count, 8'd0);
        check("p_e16_busy", busy, 1'b1);
        step(1);  check("p_e17_done", done, 1'b0);
        step(14); check("p_e31_done", done, 1'b0);
        step(1);  check("p_e32_done", done, 1'b1);
        stop = 1'b1; step(1); stop = 1'b0;
        check("p_stop_busy", busy, 1'b0);
        check("p_stop_count", count, 8'd0);

        // One-shot, load=2: single done 12 cycles after start
        load = 8'd2; mode = 1'b0; start = 1'b1;
        step(1); start = 1'b0;
        check("os_e0_busy", busy, 1'b1);
        step(11); check("os_e11_count", count, 8'd2);
        check("os_e11_done", done, 1'b0);
        step(1);  check("os_e12_done", done, 1'b1);
        check("os_e12_busy", busy, 1'b0);
        check("os_e12_count", count, 8'd0);
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (done === 1'b1 || count !== 8'd0 || busy !== 1'b0) seen_done = 1'b1;
        end
        check("os_quiet50", seen_done, 1'b0);

        // Periodic load=5 with 3 cycles of enable low and 5 cycles of pause
        load = 8'd5; mode = 1'b1; start = 1'b1;
        step(1); start = 1'b0;
        step(6);  check("fz_e6_count", count, 8'd1);
        enable = 1'b0;
        step(3);  check("fz_e9_count", count, 8'd1);
        enable = 1'b1; pause = 1'b1;
        step(5);  check("fz_e14_count", count, 8'd1);
        check("fz_e14_busy", busy, 1'b1);
        pause = 1'b0;
        step(1);  check("fz_e15_count", count, 8'd1);
        step(1);  check("fz_e16_count", count, 8'd2);
        step(15); check("fz_e31_done", done, 1'b0);
        check("fz_e31_count", count, 8'd5);
        step(1);  check("fz_e32_done", done, 1'b1);
        stop = 1'b1; step(1); stop = 1'b0;

        // load change while busy ignored; stop on the terminal-tick cycle
        load = 8'd4; mode = 1'b1; start = 1'b1;
        step(1); start = 1'b0; load = 8'd1;
        step(8);  check("ld_e8_count", count, 8'd2);
        check("ld_e8_done", done, 1'b0);
        step(11); check("ld_e19_count", count, 8'd4);
        stop = 1'b1;
        step(1); stop = 1'b0;
        check("ld_e20_done", done, 1'b0);
        check("ld_e20_busy", busy, 1'b0);
        check("ld_e20_count", count, 8'd0);
        step(1);  check("ld_e21_done", done, 1'b0);

        // PRESCALE=1, load=0 periodic: done every cycle after the first
        load1 = 8'd0; mode1 = 1'b1; start1 = 1'b1;
        step(1); start1 = 1'b0;
        check("p1_e0_done", done1, 1'b0);
        check("p1_e0_busy", busy1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check($sformatf("p1_e%0d_done", i), done1, 1'b1);
            check($sformatf("p1_e%0d_count", i), count1, 8'd0);
        end
        load1 = 8'd2; start1 = 1'b1;
        step(1); start1 = 1'b0;
        check("p1_rs_done", done1, 1'b0);
        check("p1_rs_count", count1, 8'd0);
        step(1);  check("p1_rs1_count", count1, 8'd1);
        step(1);  check("p1_rs2_count", count1, 8'd2);
        step(1);  check("p1_rs3_done", done1, 1'b1);
        check("p1_rs3_count", count1, 8'd0);
        start1 = 1'b1; stop1 = 1'b1;
        step(1); start1 = 1'b0; stop1 = 1'b0;
        check("p1_ss_busy", busy1, 1'b0);
        check("p1_ss_count", count1, 8'd0);
        check("p1_ss_done", done1, 1'b0);

        // Async reset while PAUSED at count=7 (and u_dut1 mid-done)
        load = 8'd10; mode = 1'b1; start = 1'b1;
        step(1); start = 1'b0;
        step(28); check("ar_e28_count", count, 8'd7);
        pause = 1'b1; load1 = 8'd0; mode1 = 1'b1; start1 = 1'b1;
        step(1); start1 = 1'b0;
        step(1);
        check("ar_paused_count", count, 8'd7);
        check("ar_paused_busy", busy, 1'b1);
        check("ar_dut1_done", done1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_count", count, 8'd0);
        check("ar_busy", busy, 1'b0);
        check("ar_done", done, 1'b0);
        check("ar_dut1_done0", done1, 1'b0);
        #1 reset_n = 1'b1; pause = 1'b0;
        step(10);
        check("ar_idle_busy", busy, 1'b0);
        check("ar_idle_count", count, 8'd0);
        check("ar_idle_busy1", busy1, 1'b0);
        load = 8'd3; start = 1'b1;
        step(1); start = 1'b0;
        check("ar_resume_busy", busy, 1'b1);
        step(4);  check("ar_resume_count", count, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_interval_timer.md
Name: prog_interval_timer

Overview:
- Programmable up-counting interval timer, the parametrised successor to the fixed-terminal-value timer.
- Adds runtime terminal value, an integer clock prescaler, one-shot/periodic modes, start/stop/pause control, a visible count and busy status.
- Used by display multiplexing, debouncing and LED sequencing blocks that need a software-selectable period instead of a rebuild per period.

Parameters:
- WIDTH, 16, width of terminal value and count.
- PRESCALE, 1, enabled clock cycles per count tick (>=1); prescaler width is $clog2(PRESCALE), minimum 1 bit.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  global gate; when low, prescaler and counter freeze in every state.
- start  input  1  single-cycle request: latch load/mode, clear count, enter RUN.
- stop  input  1  single-cycle request: abort to IDLE, count cleared, no done.
- pause  input  1  level; while high in RUN, timer holds (PAUSED).
- mode  input  1  0 = one-shot, 1 = periodic; sampled only on start.
- load  input  WIDTH  terminal value; sampled only on start.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or PAUSED.
- done  output  1  registered one-cycle pulse on terminal tick.

Behaviour:
- Reset (async, reset_n low): state IDLE, count=0, prescaler=0, load_reg=0, mode_reg=0, busy=0, done=0.
- States: IDLE, RUN, PAUSED.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --pause--> PAUSED.
  - PAUSED --!pause--> RUN.
  - RUN/PAUSED --stop--> IDLE.
  - RUN --terminal tick & mode_reg=0--> IDLE.
- Priority per cycle: stop > start > pause > counting.
  - start in RUN or PAUSED restarts: count=0, prescaler=0, re-latch load/mode, state RUN.
  - start and stop in the same cycle: stop wins.
- Tick: in RUN with enable=1 and pause=0, the prescaler increments; tick occurs when prescaler==PRESCALE-1 and the prescaler wraps to 0. PRESCALE=1 gives a tick on every enabled cycle.
- On tick:
  - count != load_reg: count+1.
  - count == load_reg (terminal tick): count <= 0, done <= 1 on the next edge for exactly one cycle.
- Period = (load_reg+1)*PRESCALE enabled RUN cycles between done pulses.
- load_reg=0: done pulses every PRESCALE enabled cycles in periodic mode.
- One-shot: on the terminal edge, state goes to IDLE and busy drops on the same edge that raises done.
- Periodic: stays in RUN; done repeats each period with no dead cycle.
- Freezing: enable low or PAUSED freezes prescaler and count, so a partial prescale interval is resumed, not restarted.
- stop coinciding with a terminal tick: no done pulse, count=0, state IDLE.
- Changes to load/mode while busy have no effect until the next start.
- count never exceeds load_reg; no wrap through 2^WIDTH is possible. load = 2^WIDTH-1 is legal.
- busy and count are registered; start-to-first-increment latency = PRESCALE enabled cycles after the start edge.
- reset_n asserted mid-run: immediate return to reset values, including done=0 even mid-pulse.

Test Plan (WIDTH=8, PRESCALE=4 unless noted):
- Reset, then start with load=3, mode=1, enable=1 -> count 0,1,2,3 each held 4 cycles; done pulses once every 16 cycles, 1 cycle wide; busy stays 1.
- One-shot, load=2 -> done single pulse 12 cycles after start; busy falls on the same edge; count=0 and held; no further done over 50 cycles.
- Periodic load=5; toggle enable low for 3 cycles and pause high for 5 cycles mid-interval -> period stretched by exactly 8 cycles; count and prescaler values unchanged across the freeze.
- start with load=4, change load to 1 mid-run, then stop on the exact terminal-tick cycle -> load change ignored; no done pulse; state IDLE; count=0.
- PRESCALE=1, load=0, periodic -> done high every cycle after the first, count stays 0; start re-asserted mid-run restarts cleanly; start+stop together -> IDLE.
- Assert reset_n low during PAUSED with count=7 -> count=0, busy=0, done=0 immediately (asynchronously); start required to resume.
